// File: rtl/reconf_dsp_ucode_loader_pkg.sv
// Shared definitions for the FIR microcode path: command field layout, CTRL bits,
// loader FSM states and the register address map decode.
package reconf_dsp_ucode_loader_pkg;

    // Command word fields, LSB first; the FIR decodes with the same offsets.
    localparam int RST_W         = 1;
    localparam int DSPC_W        = 2;
    localparam int OMUX_W        = 1;
    localparam int FIFO_CMDS_W   = 4;
    localparam int PC_W          = 4;
    localparam int PD_W          = 5;
    localparam int PA_W          = 5;
    localparam int B_W           = 18;
    localparam int RST_OFF       = 0;
    localparam int DSPC_OFF      = RST_OFF + RST_W;
    localparam int OMUX_OFF      = DSPC_OFF + DSPC_W;
    localparam int FIFO_CMDS_OFF = OMUX_OFF + OMUX_W;
    localparam int PC_OFF        = FIFO_CMDS_OFF + FIFO_CMDS_W;
    localparam int PD_OFF        = PC_OFF + PC_W;
    localparam int PA_OFF        = PD_OFF + PD_W;
    localparam int B_OFF         = PA_OFF + PA_W;
    localparam int UCODE_CMD_W   = B_OFF + B_W;

    localparam int CTRL_START_BIT  = 0;
    localparam int CTRL_COMMIT_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RST   = 2'd1,
        ST_SHIFT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ADDR_LO   = 2'd0,
        ADDR_HI   = 2'd1,
        ADDR_CTRL = 2'd2,
        ADDR_NONE = 2'd3
    } addr_kind_e;

    typedef struct packed {
        addr_kind_e  kind;
        logic [15:0] stage;
    } addr_dec_t;

    // Even addresses hold word bits [31:0], odd ones the upper bits; CTRL follows the stages.
    function automatic addr_dec_t decode_addr(input int unsigned addr, input int unsigned stages);
        addr_dec_t d;
        d.stage = 16'(addr >> 1);
        if (addr < 2 * stages)
            d.kind = addr[0] ? ADDR_HI : ADDR_LO;
        else if (addr == 2 * stages)
            d.kind = ADDR_CTRL;
        else
            d.kind = ADDR_NONE;
        return d;
    endfunction

endpackage

// File: rtl/reconf_dsp_ucode_loader_slice_ser.sv
// Per-stage parallel-load shift register: emits one SLICE_W slice per beat, MSB first,
// from the command word zero-padded to BEATS*SLICE_W bits.
module reconf_dsp_slice_ser #(
    parameter int CMD_W   = 40,
    parameter int SLICE_W = 4,
    parameter int BEATS   = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               shift,
    input  logic [CMD_W-1:0]   din,
    output logic [SLICE_W-1:0] slice
);
    localparam int PAD_W = BEATS * SLICE_W;

    logic [PAD_W-1:0] sr;

    // Zeros shift in behind the word, so the slice output is zero once all beats are out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            sr <= '0;
        else if (load)
            sr <= PAD_W'(din);
        else if (shift)
            sr <= sr << SLICE_W;
    end

    assign slice = sr[PAD_W-1 -: SLICE_W];

endmodule

// File: rtl/reconf_dsp_ucode_loader.sv
// Host-side microcode loader: stages per-stage command words from register writes and
// serialises them onto the FIR cfg bus on COMMIT; START pulses the sequencer reset.
module reconf_dsp_ucode_loader
    import reconf_dsp_ucode_loader_pkg::*;
#(
    parameter int STAGES     = 8,
    parameter int CFG_WIDTH  = 32,
    parameter int CMD_W      = reconf_dsp_ucode_loader_pkg::UCODE_CMD_W,
    parameter int DEPTH      = 32,
    parameter int RST_CYCLES = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    input  logic [$clog2(2*STAGES+1)-1:0]   wr_addr,
    input  logic [31:0]                     wr_data,
    output logic                            wr_ready,
    output logic                            cfg_rst,
    output logic                            cfg_valid,
    output logic [CFG_WIDTH-1:0]            cfg_data,
    output logic                            busy,
    output logic [$clog2(DEPTH+1)-1:0]      words_loaded,
    output logic                            err_ovf
);
    localparam int SLICE_W = CFG_WIDTH / STAGES;
    localparam int BEATS   = (CMD_W + SLICE_W - 1) / SLICE_W;
    localparam int RCNT_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WL_W    = $clog2(DEPTH + 1);

    // Handshake: a write transfers on a cycle where wr_valid && wr_ready; wr_ready is
    // high only in IDLE, so CTRL and staging writes never overlap an RST or SHIFT run.
    state_e            state, state_next;
    logic [RCNT_W-1:0] cnt, cnt_next;
    logic [BEAT_W-1:0] beat, beat_next;
    logic [WL_W-1:0]   wl_next;
    logic              err_next;
    logic              load, shift;
    logic              accept, start, commit;
    addr_dec_t         dec;
    logic [CMD_W-1:0]  staging [STAGES];

    assign wr_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = wr_valid && wr_ready;
    assign dec      = decode_addr(32'(wr_addr), STAGES);
    assign start    = accept && (dec.kind == ADDR_CTRL) && wr_data[CTRL_START_BIT];
    assign commit   = accept && (dec.kind == ADDR_CTRL) && wr_data[CTRL_COMMIT_BIT]
                      && !wr_data[CTRL_START_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++)
                staging[s] <= '0;
        end else if (accept) begin
            for (int s = 0; s < STAGES; s++) begin
                if (dec.kind == ADDR_LO && dec.stage == 16'(s))
                    staging[s][31:0] <= wr_data;
                if (dec.kind == ADDR_HI && dec.stage == 16'(s))
                    staging[s][CMD_W-1:32] <= wr_data[CMD_W-33:0];
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        beat_next  = beat;
        wl_next    = words_loaded;
        err_next   = err_ovf;
        load       = 1'b0;
        shift      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RST;
                    cnt_next   = RCNT_W'(RST_CYCLES - 1);
                    wl_next    = '0;
                    err_next   = 1'b0;
                end else if (commit) begin
                    if (words_loaded >= WL_W'(DEPTH)) begin
                        err_next = 1'b1;
                    end else begin
                        state_next = ST_SHIFT;
                        load       = 1'b1;
                        beat_next  = '0;
                    end
                end
            end
            ST_RST: begin
                if (cnt == '0)
                    state_next = ST_IDLE;
                else
                    cnt_next = cnt - 1'b1;
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (beat == BEAT_W'(BEATS - 1)) begin
                    state_next = ST_IDLE;
                    wl_next    = words_loaded + 1'b1;
                end else begin
                    beat_next = beat + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // cfg_rst/cfg_valid are flopped from the next state so they align with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            beat         <= '0;
            words_loaded <= '0;
            err_ovf      <= 1'b0;
            cfg_rst      <= 1'b1;
            cfg_valid    <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            beat         <= beat_next;
            words_loaded <= wl_next;
            err_ovf      <= err_next;
            cfg_rst      <= (state_next == ST_RST);
            cfg_valid    <= (state_next == ST_SHIFT);
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        reconf_dsp_slice_ser #(
            .CMD_W   (CMD_W),
            .SLICE_W (SLICE_W),
            .BEATS   (BEATS)
        ) u_ser (
            .clk   (clk),
            .rst   (rst),
            .load  (load),
            .shift (shift),
            .din   (staging[s]),
            .slice (cfg_data[SLICE_W*s +: SLICE_W])
        );
    end

endmodule

// File: tb/tb_reconf_dsp_ucode_loader.sv
// Directed bench for the microcode loader: reset, START, single/all-stage commits,
// back-to-back commits, overflow and async reset during a shift.
module tb_reconf_dsp_ucode_loader;
    localparam int STAGES    = 8;
    localparam int CFG_WIDTH = 32;
    localparam int CMD_W     = 40;
    localparam int DEPTH     = 32;
    localparam int BEATS     = 10;
    localparam int AW        = 5;
    localparam int WLW       = 6;
    localparam logic [AW-1:0] CTRL_ADDR = 5'd16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 wr_valid = 1'b0;
    logic [AW-1:0]        wr_addr = '0;
    logic [31:0]          wr_data = '0;
    logic                 wr_ready, cfg_rst, cfg_valid, busy, err_ovf;
    logic [CFG_WIDTH-1:0] cfg_data;
    logic [WLW-1:0]       words_loaded;

    int total_cnt = 0;
    int pass_cnt  = 0;
    int cyc = 0;
    int last_acc = 0;
    int vld_cycles, rst_cycles, busy_cycles, first_vld, last_vld, stray_data;
    logic [CFG_WIDTH-1:0] exp_q[$];
    logic [CFG_WIDTH-1:0] got_q[$];
    logic [CMD_W-1:0]     words [STAGES];

    reconf_dsp_ucode_loader dut (
        .clk          (clk),
        .rst          (rst),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .cfg_rst      (cfg_rst),
        .cfg_valid    (cfg_valid),
        .cfg_data     (cfg_data),
        .busy         (busy),
        .words_loaded (words_loaded),
        .err_ovf      (err_ovf)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver tasks
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!wr_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            total_cnt++;
            $display("FAIL wait_idle: wr_ready=%b required 1 within 200 cycles", wr_ready);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [31:0] data);
        wait_idle();
        wr_valid = 1'b1;
        wr_addr  = addr;
        wr_data  = data;
        @(posedge clk);
        #1;
        last_acc = cyc;
        wr_valid = 1'b0;
    endtask

    task automatic write_word(input int s, input logic [CMD_W-1:0] w);
        do_write(AW'(2 * s), w[31:0]);
        do_write(AW'(2 * s + 1), {24'hA5A5A5, w[CMD_W-1:32]});
    endtask

    task automatic capture(input int ncyc);
        got_q.delete();
        vld_cycles = 0; rst_cycles = 0; busy_cycles = 0;
        first_vld = -1; last_vld = -1; stray_data = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (cfg_valid) begin
                got_q.push_back(cfg_data);
                vld_cycles++;
                if (first_vld < 0) first_vld = i;
                last_vld = i;
            end else if (cfg_data != '0) begin
                stray_data++;
            end
            if (cfg_rst) rst_cycles++;
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    // Scenario tasks
    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (cfg_rst !== 1'b1) $display("FAIL reset_cfg_rst: got %b expected 1", cfg_rst); else pass_cnt++;
        total_cnt++; if (cfg_valid !== 1'b0) $display("FAIL reset_cfg_valid: got %b expected 0", cfg_valid); else pass_cnt++;
        total_cnt++; if (cfg_data !== '0) $display("FAIL reset_cfg_data: got %h expected 0", cfg_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL reset_err_ovf: got %b expected 0", err_ovf); else pass_cnt++;
        total_cnt++; if (words_loaded !== 6'd0) $display("FAIL reset_words: got %0d expected 0", words_loaded); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (cfg_rst !== 1'b1) $display("FAIL release_cfg_rst_held: got %b expected 1", cfg_rst); else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++; if (cfg_rst !== 1'b0) $display("FAIL release_cfg_rst_low: got %b expected 0", cfg_rst); else pass_cnt++;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL release_wr_ready: got %b expected 1", wr_ready); else pass_cnt++;
    endtask

    task automatic test_single_stage();
        logic [3:0] nib [BEATS];
        logic [CFG_WIDTH-1:0] got;
        nib = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
        do_write(5'd0, 32'h3456789A);
        do_write(5'd1, 32'hFFFFFF12);
        do_write(CTRL_ADDR, 32'd2);
        capture(16);
        total_cnt++; if (vld_cycles != BEATS) $display("FAIL single_beats: got %0d expected %0d", vld_cycles, BEATS); else pass_cnt++;
        total_cnt++; if (first_vld != 0 || last_vld != BEATS - 1) $display("FAIL single_window: got %0d..%0d expected 0..9", first_vld, last_vld); else pass_cnt++;
        total_cnt++; if (busy_cycles != BEATS) $display("FAIL single_busy: got %0d expected %0d", busy_cycles, BEATS); else pass_cnt++;
        total_cnt++; if (stray_data != 0) $display("FAIL single_stray: got %0d expected 0", stray_data); else pass_cnt++;
        for (int k = 0; k < BEATS; k++) begin
            got = (k < got_q.size()) ? got_q[k] : 'x;
            total_cnt++; if (got !== {28'h0, nib[k]}) $display("FAIL single_beat%0d: got %h expected %h", k, got, {28'h0, nib[k]}); else pass_cnt++;
        end
        total_cnt++; if (words_loaded !== 6'd1) $display("FAIL single_words: got %0d expected 1", words_loaded); else pass_cnt++;
    endtask

    task automatic test_start();
        do_write(CTRL_ADDR, 32'd1);
        total_cnt++; if (words_loaded !== 6'd0) $display("FAIL start_words: got %0d expected 0", words_loaded); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (cfg_rst !== 1'b1) $display("FAIL start_cfg_rst_c%0d: got %b expected 1", i, cfg_rst); else pass_cnt++;
            total_cnt++; if (wr_ready !== 1'b0) $display("FAIL start_wr_ready_c%0d: got %b expected 0", i, wr_ready); else pass_cnt++;
            @(posedge clk);
            #1;
        end
        total_cnt++; if (cfg_rst !== 1'b0) $display("FAIL start_cfg_rst_end: got %b expected 0", cfg_rst); else pass_cnt++;
        total_cnt++; if (wr_ready !== 1'b1) $display("FAIL start_wr_ready_end: got %b expected 1", wr_ready); else pass_cnt++;
    endtask

    task automatic test_all_stages();
        logic [CFG_WIDTH-1:0] e, got;
        logic [CMD_W-1:0] rx [STAGES];
        words = '{40'h01_23456789, 40'hAB_CDEF0123, 40'h45_6789ABCD, 40'hEF_01234567,
                  40'h89_ABCDEF01, 40'h23_456789AB, 40'hCD_EF012345, 40'hFF_FFFFFFFF};
        for (int s = 0; s < STAGES; s++) write_word(s, words[s]);
        do_write(CTRL_ADDR, 32'd2);
        capture(14);
        exp_q.delete();
        for (int k = 0; k < BEATS; k++) begin
            e = '0;
            for (int s = 0; s < STAGES; s++) e[s*4 +: 4] = words[s][(BEATS-1-k)*4 +: 4];
            exp_q.push_back(e);
        end
        total_cnt++; if (vld_cycles != BEATS) $display("FAIL all_beats: got %0d expected %0d", vld_cycles, BEATS); else pass_cnt++;
        for (int s = 0; s < STAGES; s++) rx[s] = '0;
        for (int k = 0; k < BEATS; k++) begin
            got = (k < got_q.size()) ? got_q[k] : 'x;
            total_cnt++; if (got !== exp_q[k]) $display("FAIL all_beat%0d: got %h expected %h", k, got, exp_q[k]); else pass_cnt++;
            for (int s = 0; s < STAGES; s++) rx[s] = {rx[s][CMD_W-5:0], got[s*4 +: 4]};
        end
        for (int s = 0; s < STAGES; s++) begin
            total_cnt++; if (rx[s] !== words[s]) $display("FAIL all_rx_stage%0d: got %h expected %h", s, rx[s], words[s]); else pass_cnt++;
        end
        total_cnt++; if (words_loaded !== 6'd1) $display("FAIL all_words: got %0d expected 1", words_loaded); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int t0, bad;
        logic [CMD_W-1:0] rx [STAGES];
        do_write(CTRL_ADDR, 32'd2);
        t0 = last_acc;
        do_write(CTRL_ADDR, 32'd2);
        total_cnt++; if (last_acc - t0 != BEATS + 1) $display("FAIL b2b_period: got %0d expected %0d", last_acc - t0, BEATS + 1); else pass_cnt++;
        capture(14);
        total_cnt++; if (vld_cycles != BEATS) $display("FAIL b2b_beats: got %0d expected %0d", vld_cycles, BEATS); else pass_cnt++;
        bad = 0;
        for (int s = 0; s < STAGES; s++) rx[s] = '0;
        for (int k = 0; k < got_q.size(); k++)
            for (int s = 0; s < STAGES; s++) rx[s] = {rx[s][CMD_W-5:0], got_q[k][s*4 +: 4]};
        for (int s = 0; s < STAGES; s++) if (rx[s] !== words[s]) bad++;
        total_cnt++; if (bad != 0) $display("FAIL b2b_resend: got %0d wrong stages expected 0", bad); else pass_cnt++;
        total_cnt++; if (words_loaded !== 6'd3) $display("FAIL b2b_words: got %0d expected 3", words_loaded); else pass_cnt++;
    endtask

    task automatic test_overflow();
        do_write(CTRL_ADDR, 32'd1);
        for (int i = 0; i < DEPTH; i++) do_write(CTRL_ADDR, 32'd2);
        wait_idle();
        total_cnt++; if (words_loaded !== 6'd32) $display("FAIL ovf_words_full: got %0d expected 32", words_loaded); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL ovf_err_before: got %b expected 0", err_ovf); else pass_cnt++;
        do_write(CTRL_ADDR, 32'd2);
        capture(14);
        total_cnt++; if (vld_cycles != 0) $display("FAIL ovf_no_beats: got %0d expected 0", vld_cycles); else pass_cnt++;
        total_cnt++; if (busy_cycles != 0) $display("FAIL ovf_busy: got %0d expected 0", busy_cycles); else pass_cnt++;
        total_cnt++; if (err_ovf !== 1'b1) $display("FAIL ovf_err_set: got %b expected 1", err_ovf); else pass_cnt++;
        total_cnt++; if (words_loaded !== 6'd32) $display("FAIL ovf_words_hold: got %0d expected 32", words_loaded); else pass_cnt++;
        do_write(CTRL_ADDR, 32'd1);
        wait_idle();
        total_cnt++; if (err_ovf !== 1'b0) $display("FAIL ovf_err_clear: got %b expected 0", err_ovf); else pass_cnt++;
        total_cnt++; if (words_loaded !== 6'd0) $display("FAIL ovf_words_clear: got %0d expected 0", words_loaded); else pass_cnt++;
    endtask

    task automatic test_async_mid_shift();
        int nz;
        write_word(3, 40'h5A_CAFEF00D);
        do_write(CTRL_ADDR, 32'd2);
        repeat (5) @(posedge clk);
        #1;
        total_cnt++; if (cfg_valid !== 1'b1) $display("FAIL mid_valid_b5: got %b expected 1", cfg_valid); else pass_cnt++;
        total_cnt++; if (cfg_data[15:12] !== 4'hE) $display("FAIL mid_stage3_b5: got %h expected e", cfg_data[15:12]); else pass_cnt++;
        #2 rst = 1'b0;
        #1;
        total_cnt++; if (cfg_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", cfg_valid); else pass_cnt++;
        total_cnt++; if (cfg_rst !== 1'b1) $display("FAIL arst_cfg_rst: got %b expected 1", cfg_rst); else pass_cnt++;
        total_cnt++; if (cfg_data !== '0) $display("FAIL arst_data: got %h expected 0", cfg_data); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++; if (busy !== 1'b0 || cfg_rst !== 1'b0) $display("FAIL arst_release: got busy=%b cfg_rst=%b expected 0/0", busy, cfg_rst); else pass_cnt++;
        do_write(CTRL_ADDR, 32'd3);
        capture(14);
        total_cnt++; if (rst_cycles != 4) $display("FAIL both_rst_cycles: got %0d expected 4", rst_cycles); else pass_cnt++;
        total_cnt++; if (vld_cycles != 0) $display("FAIL both_no_beats: got %0d expected 0", vld_cycles); else pass_cnt++;
        do_write(CTRL_ADDR, 32'd2);
        capture(14);
        nz = 0;
        foreach (got_q[k]) if (got_q[k] !== '0) nz++;
        total_cnt++; if (vld_cycles != BEATS) $display("FAIL post_beats: got %0d expected %0d", vld_cycles, BEATS); else pass_cnt++;
        total_cnt++; if (nz != 0) $display("FAIL post_staging_zero: got %0d nonzero beats expected 0", nz); else pass_cnt++;
        total_cnt++; if (words_loaded !== 6'd1) $display("FAIL post_words: got %0d expected 1", words_loaded); else pass_cnt++;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_single_stage();
        test_start();
        test_all_stages();
        test_back_to_back();
        test_overflow();
        test_async_mid_shift();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
